// File: rtl/serdes_deskew_pkg.sv
// Shared types, sync-header codes and the alignment-marker test used by the
// multi-lane deskew block.
package serdes_deskew_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        ALIGNED = 2'd2,
        ERROR   = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SEARCH  = SEARCH;
    localparam logic [1:0] ST_ALIGNED = ALIGNED;
    localparam logic [1:0] ST_ERROR   = ERROR;

    localparam logic [1:0] SYNC_OS   = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    localparam logic [7:0] DEFAULT_MARKER_SYM = 8'hAA;

    // Only the sync header and first symbol of a block identify a marker.
    function automatic logic is_marker(input logic [9:0] block, input logic [7:0] sym);
        return (block[1:0] == SYNC_OS) && (block[9:2] == sym);
    endfunction

endpackage

// File: rtl/deskew_lane_fifo.sv
// Per-lane elastic FIFO with a combinational head; absorbs one lane's skew.
module deskew_lane_fifo #(
    parameter  int LANE_W   = 130,
    parameter  int MAX_SKEW = 8,
    localparam int CNT_W    = $clog2(MAX_SKEW + 1),
    localparam int PTR_W    = (MAX_SKEW > 1) ? $clog2(MAX_SKEW) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [LANE_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [LANE_W-1:0] mem [MAX_SKEW];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_wr;
    logic              do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_SKEW - 1)) ? '0 : p + 1'b1;
    endfunction

    // A write into a full FIFO is accepted only when a pop frees a slot.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_rd) rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(MAX_SKEW));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/serdes_multilane_deskew.sv
// Multi-lane receive aligner: locks per-lane FIFOs on a common alignment marker,
// pops all lanes in lockstep, strips coincident markers and flags misalignment.
import serdes_deskew_pkg::*;

module serdes_multilane_deskew #(
    parameter  int         NUM_LANES  = 4,
    parameter  int         LANE_W     = 130,
    parameter  int         MAX_SKEW   = 8,
    parameter  logic [7:0] MARKER_SYM = DEFAULT_MARKER_SYM,
    localparam int         CNT_W      = $clog2(MAX_SKEW + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          align_req,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES*LANE_W-1:0]   lane_data,
    output logic                          out_valid,
    output logic [NUM_LANES*LANE_W-1:0]   out_data,
    output logic                          aligned,
    output logic                          deskew_error,
    output logic [CNT_W-1:0]              skew_max
);

    logic [1:0]                    state_reg, state_next;
    logic [NUM_LANES-1:0]          marker_seen_reg, marker_seen_next;
    logic [NUM_LANES-1:0]          lane_marker, head_marker, seen_now;
    logic [NUM_LANES-1:0]          wr_en, full, empty;
    logic [LANE_W-1:0]             head [NUM_LANES];
    logic [CNT_W-1:0]              count [NUM_LANES];
    logic [NUM_LANES*LANE_W-1:0]   heads;
    logic [CNT_W-1:0]              cnt_max, cnt_min;
    logic                          flush, pop, out_fire, lock;

    logic                          out_valid_reg;
    logic [NUM_LANES*LANE_W-1:0]   out_data_reg;
    logic                          deskew_error_reg;
    logic [CNT_W-1:0]              skew_max_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_marker[gi] = is_marker(lane_data[gi*LANE_W +: 10], MARKER_SYM);
            assign head_marker[gi] = is_marker(head[gi][9:0], MARKER_SYM);
            assign heads[gi*LANE_W +: LANE_W] = head[gi];

            deskew_lane_fifo #(
                .LANE_W   (LANE_W),
                .MAX_SKEW (MAX_SKEW)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .wr_en   (wr_en[gi]),
                .wr_data (lane_data[gi*LANE_W +: LANE_W]),
                .rd_en   (pop),
                .rd_data (head[gi]),
                .count   (count[gi]),
                .full    (full[gi]),
                .empty   (empty[gi])
            );
        end
    endgenerate

    // A lane that sees its marker this cycle counts as locked for the lock decision.
    assign seen_now = marker_seen_reg | (lane_valid & lane_marker);

    always_comb begin
        cnt_max = '0;
        cnt_min = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (count[i] > cnt_max) cnt_max = count[i];
            if (count[i] < cnt_min) cnt_min = count[i];
        end
    end

    always_comb begin
        state_next       = state_reg;
        marker_seen_next = marker_seen_reg;
        wr_en            = '0;
        pop              = 1'b0;
        flush            = 1'b0;
        if (align_req) begin
            flush            = 1'b1;
            marker_seen_next = '0;
            state_next       = ST_SEARCH;
        end else begin
            case (state_reg)
                ST_SEARCH: begin
                    wr_en            = lane_valid & seen_now;
                    marker_seen_next = seen_now;
                    if (|(wr_en & full))  state_next = ST_ERROR;
                    else if (&seen_now)   state_next = ST_ALIGNED;
                    else if (|full)       state_next = ST_ERROR;
                end
                ST_ALIGNED: begin
                    wr_en = lane_valid;
                    pop   = &(~empty);
                    // Markers on only some lanes mean a lane has slipped.
                    if (pop && (|head_marker) && !(&head_marker)) state_next = ST_ERROR;
                    else if (!pop && |(wr_en & full))             state_next = ST_ERROR;
                end
                default: ;
            endcase
        end
    end

    assign out_fire = pop && (head_marker == '0);
    assign lock     = (state_reg == ST_SEARCH) && !align_req && (state_next == ST_ALIGNED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            marker_seen_reg  <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            deskew_error_reg <= 1'b0;
            skew_max_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            marker_seen_reg <= marker_seen_next;
            out_valid_reg   <= out_fire;
            if (out_fire) out_data_reg <= heads;
            if (align_req)                    deskew_error_reg <= 1'b0;
            else if (state_next == ST_ERROR)  deskew_error_reg <= 1'b1;
            if (lock) skew_max_reg <= cnt_max - cnt_min;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign aligned      = (state_reg == ST_ALIGNED);
    assign deskew_error = deskew_error_reg;
    assign skew_max     = skew_max_reg;

endmodule

// File: tb/tb_serdes_multilane_deskew.sv
// Directed bench for the multi-lane deskew aligner: lock, skew, overflow,
// marker slip, periodic marker stripping, relock and asynchronous reset.
module tb_serdes_multilane_deskew;
    import serdes_deskew_pkg::*;

    localparam int NL = 4;
    localparam int LW = 130;
    localparam int MS = 8;
    localparam int CW = $clog2(MS + 1);

    logic                clk;
    logic                rst;
    logic                align_req;
    logic [NL-1:0]       lane_valid;
    logic [NL*LW-1:0]    lane_data;
    logic                out_valid;
    logic [NL*LW-1:0]    out_data;
    logic                aligned;
    logic                deskew_error;
    logic [CW-1:0]       skew_max;

    int checks = 0;
    int errors = 0;
    int dly [NL];
    int last_j;

    serdes_multilane_deskew #(
        .NUM_LANES  (NL),
        .LANE_W     (LW),
        .MAX_SKEW   (MS),
        .MARKER_SYM (8'hAA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .align_req    (align_req),
        .lane_valid   (lane_valid),
        .lane_data    (lane_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .aligned      (aligned),
        .deskew_error (deskew_error),
        .skew_max     (skew_max)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] mk_data(input int lane, input int j);
        return {112'd0, 8'(lane), 8'(j), SYNC_DATA};
    endfunction

    function automatic logic [LW-1:0] mk_marker();
        return {120'd0, 8'hAA, SYNC_OS};
    endfunction

    function automatic logic [NL*LW-1:0] exp_vec(input int j);
        logic [NL*LW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*LW +: LW] = mk_data(i, j);
        return v;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [NL*LW-1:0] obs, input logic [NL*LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // align_req, then lane i sends its marker at cycle dly[i] followed by data j=1,2,...
    // Every j that is a multiple of period is sent as a marker on all lanes.
    // err_at < 0 expects a lock; otherwise deskew_error is expected from that cycle on.
    task automatic run_stream(input int ncyc, input int period, input int err_at);
        int maxd, mind, j;
        logic ev;
        maxd   = 0;
        mind   = 1000;
        last_j = 0;
        for (int i = 0; i < NL; i++) begin
            if (dly[i] > maxd) maxd = dly[i];
            if (dly[i] < mind) mind = dly[i];
        end
        align_req  = 1'b1;
        lane_valid = '0;
        cyc();
        align_req = 1'b0;
        chk_bit("req_aligned", aligned, 1'b0);
        chk_bit("req_error", deskew_error, 1'b0);
        chk_bit("req_valid", out_valid, 1'b0);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NL; i++) begin
                j = c - dly[i];
                lane_valid[i] = (j >= 0);
                lane_data[i*LW +: LW] = (j >= 0 && (j % period) == 0) ? mk_marker() : mk_data(i, j);
            end
            cyc();
            if (err_at < 0) begin
                j  = c - maxd - 1;
                ev = (j >= 1) && ((j % period) != 0);
                chk_bit($sformatf("valid_c%0d", c), out_valid, ev);
                if (ev) begin
                    chk_vec($sformatf("data_j%0d", j), out_data, exp_vec(j));
                    last_j = j;
                end else if (last_j >= 1) begin
                    chk_vec($sformatf("hold_c%0d", c), out_data, exp_vec(last_j));
                end
                chk_bit($sformatf("aligned_c%0d", c), aligned, c >= maxd);
                if (c == maxd) chk_int("skew_max", int'(skew_max), maxd - mind);
            end else begin
                chk_bit($sformatf("err_valid_c%0d", c), out_valid, 1'b0);
                chk_bit($sformatf("err_flag_c%0d", c), deskew_error, c >= err_at);
                chk_bit($sformatf("err_aligned_c%0d", c), aligned, 1'b0);
            end
            $display("stream c=%0d valid=%b aligned=%b err=%b skew=%0d", c, out_valid, aligned, deskew_error, skew_max);
        end
        lane_valid = '0;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        align_req  = 1'b0;
        lane_valid = '0;
        lane_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_bit("rst_aligned", aligned, 1'b0);
        chk_bit("rst_error", deskew_error, 1'b0);
        chk_int("rst_skew", int'(skew_max), 0);
        chk_vec("rst_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk_bit("idle_aligned", aligned, 1'b0);

        // Zero skew
        dly = '{0, 0, 0, 0};
        run_stream(6, 1000, -1);
        repeat (3) cyc();

        // Marker slip: lane 2 marker one cycle late after lock
        lane_valid = '1;
        for (int i = 0; i < NL; i++) lane_data[i*LW +: LW] = (i == 2) ? mk_data(i, 50) : mk_marker();
        cyc();
        chk_bit("slip_a_error", deskew_error, 1'b0);
        chk_bit("slip_a_aligned", aligned, 1'b1);
        for (int i = 0; i < NL; i++) lane_data[i*LW +: LW] = (i == 2) ? mk_marker() : mk_data(i, 51);
        cyc();
        chk_bit("slip_b_error", deskew_error, 1'b1);
        chk_bit("slip_b_aligned", aligned, 1'b0);
        chk_bit("slip_b_valid", out_valid, 1'b0);
        lane_valid = '0;
        cyc();
        chk_bit("slip_sticky", deskew_error, 1'b1);
        $display("slip err=%b aligned=%b", deskew_error, aligned);

        // Skew 0/2/5/3
        dly = '{0, 2, 5, 3};
        run_stream(16, 1000, -1);

        // Skew beyond FIFO depth
        dly = '{0, 0, 0, 9};
        run_stream(12, 1000, 8);

        // Periodic markers every 16 blocks
        dly = '{1, 0, 2, 0};
        run_stream(40, 16, -1);

        // Relock while aligned with FIFOs holding data
        dly = '{3, 1, 0, 2};
        run_stream(14, 1000, -1);

        // Asynchronous reset mid-stream
        dly = '{0, 2, 1, 3};
        run_stream(10, 1000, -1);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("arst_valid", out_valid, 1'b0);
        chk_bit("arst_aligned", aligned, 1'b0);
        chk_bit("arst_error", deskew_error, 1'b0);
        chk_int("arst_skew", int'(skew_max), 0);
        chk_vec("arst_data", out_data, '0);
        $display("async reset valid=%b aligned=%b", out_valid, aligned);
        @(negedge clk);
        rst = 1'b0;
        lane_valid = '1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NL; i++) lane_data[i*LW +: LW] = (c == 0) ? mk_marker() : mk_data(i, c);
            cyc();
            chk_bit($sformatf("post_rst_valid_c%0d", c), out_valid, 1'b0);
            chk_bit($sformatf("post_rst_aligned_c%0d", c), aligned, 1'b0);
            $display("post reset c=%0d valid=%b aligned=%b", c, out_valid, aligned);
        end
        lane_valid = '0;

        // Recovery after reset
        dly = '{0, 0, 0, 0};
        run_stream(6, 1000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
